// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer and FIFO write-side signals of the FIFO write arbiter
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int PTR_WIDTH = 4
);
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*WIDTH-1:0] wdata_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic                     fifo_wr_en_o;
    logic [WIDTH-1:0]         fifo_wdata_o;
    logic                     fifo_rd_ack_i;
    logic                     fifo_wr_error_i;
    logic [PTR_WIDTH:0]       count_o;
    logic                     err_o;

    modport slave (
        input  req_i, wdata_i, fifo_rd_ack_i, fifo_wr_error_i,
        output gnt_o, fifo_wr_en_o, fifo_wdata_o, count_o, err_o
    );

    modport master (
        output req_i, wdata_i, fifo_rd_ack_i, fifo_wr_error_i,
        input  gnt_o, fifo_wr_en_o, fifo_wdata_o, count_o, err_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port, with credit tracking
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4,
    parameter int BURST_MAX = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int CW = PTR_WIDTH + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [BW-1:0]    beats_q, beats_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en_q, wr_en_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             err_q, err_d;

    logic             grant;
    logic [OW-1:0]    gnt_idx;
    logic             win_found;
    logic [OW-1:0]    win_idx;
    logic             credit;
    logic             rd_eff;
    int               idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= OW'(NUM_REQ - 1);
            beats_q <= '0;
            count_q <= '0;
            wr_en_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beats_q <= beats_d;
            count_q <= count_d;
            wr_en_q <= wr_en_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        // Rotating search: the current owner is examined last, so it is lowest priority
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(owner_q) + k) % NUM_REQ;
            if (!win_found && bus.req_i[idx]) begin
                win_found = 1'b1;
                win_idx   = OW'(idx);
            end
        end

        credit  = (count_q < CW'(DEPTH));
        grant   = 1'b0;
        gnt_idx = owner_q;
        state_d = state_q;
        owner_d = owner_q;
        beats_d = beats_q;

        if (state_q == BURST && bus.req_i[owner_q] && beats_q < BW'(BURST_MAX)) begin
            // Without credit the burst stalls in place and resumes later
            if (credit) begin
                grant   = 1'b1;
                beats_d = beats_q + BW'(1);
            end
        end else if (win_found && credit) begin
            grant   = 1'b1;
            gnt_idx = win_idx;
            owner_d = win_idx;
            beats_d = BW'(1);
            state_d = (BURST_MAX == 1) ? IDLE : BURST;
        end else begin
            state_d = IDLE;
        end

        rd_eff = bus.fifo_rd_ack_i && (count_q != '0);
        case ({grant, rd_eff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        err_d   = err_q | bus.fifo_wr_error_i | (bus.fifo_rd_ack_i && (count_q == '0));
        wr_en_d = grant;
        wdata_d = grant ? bus.wdata_i[int'(gnt_idx)*WIDTH +: WIDTH] : wdata_q;
    end

    always_comb begin
        bus.gnt_o = '0;
        if (grant && !rst_i) begin
            bus.gnt_o[gnt_idx] = 1'b1;
        end
        bus.fifo_wr_en_o = wr_en_q;
        bus.fifo_wdata_o = wdata_q;
        bus.count_o      = count_q;
        bus.err_o        = err_q;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the write port of one synchronous FIFO (DEPTH x WIDTH) between NUM_REQ producers.
- Arbitration: round-robin, with bounded bursts.
- Overflow protection: the block keeps its own occupancy count, so it never over-issues even though its FIFO write is registered.
- Placement: sits between the producer blocks and the FIFO's wr_en/wdata inputs. It observes the FIFO's accepted reads and write-error flag.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, data width, equal to the FIFO WIDTH
DEPTH, 16, FIFO depth, used as the credit limit
PTR_WIDTH, 4, log2(DEPTH); count width is PTR_WIDTH+1
BURST_MAX, 4, maximum consecutive beats one owner may hold the grant (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
req_i  in  NUM_REQ  per-requester write request; held until granted
wdata_i  in  NUM_REQ*WIDTH  requester data, slice i = [i*WIDTH +: WIDTH]
gnt_o  out  NUM_REQ  one-hot combinational acknowledge; data on slice i is consumed at this edge
fifo_wr_en_o  out  1  registered FIFO write enable
fifo_wdata_o  out  WIDTH  registered FIFO write data
fifo_rd_ack_i  in  1  high for one cycle per FIFO read actually performed (rd_en and not empty)
fifo_wr_error_i  in  1  FIFO write-error flag
count_o  out  PTR_WIDTH+1  arbiter's view of FIFO occupancy, 0..DEPTH
err_o  out  1  sticky: FIFO reported a write error; cleared only by reset

Behaviour:
- Reset (async, while rst_i=1) drives:
  - gnt_o=0, fifo_wr_en_o=0, fifo_wdata_o=0, count_o=0, err_o=0
  - state=IDLE, owner=NUM_REQ-1, so requester 0 wins first; beat counter=0
- Reset mid-burst abandons the burst and any pending write. Reset does not reset the FIFO itself.
- Credit rule: a grant is allowed only when count_o < DEPTH. This is evaluated on the registered count; a same-cycle rd_ack does not create credit.
- gnt_o decode: combinational from state, owner, beat counter, req_i and count_o. At most one bit is high. It is forced to 0 while rst_i=1.
- Posedge where gnt_o[i]=1:
  - fifo_wr_en_o<=1 and fifo_wdata_o<=slice i.
  - The write reaches the FIFO one cycle after the grant.
  - Otherwise fifo_wr_en_o<=0 and fifo_wdata_o holds its value.
- Count update at each posedge: +1 on grant, -1 on fifo_rd_ack_i, unchanged when both occur. A rd_ack at count 0 is ignored (no underflow) and sets err_o.
- err_o is set on any cycle with fifo_wr_error_i=1 (this indicates a credit mismatch).
- FSM IDLE:
  - Search req_i from index owner+1, modulo NUM_REQ; the first set bit wins.
  - If there is credit: grant, owner<=winner, beats<=1, go to BURST (or stay in IDLE if BURST_MAX=1).
  - With no request or no credit, stay in IDLE.
- FSM BURST:
  - If req_i[owner]=1 and beats<BURST_MAX and credit: grant owner, beats<=beats+1.
  - Else if the owner has dropped req or beats=BURST_MAX: re-arbitrate in the same cycle exactly as in IDLE, with owner as lowest priority. A win gives beats<=1 and stays in BURST; no win goes to IDLE.
  - Else (owner still requesting, beats<BURST_MAX, no credit): stall. No grant, state and beats hold, and the burst resumes when credit returns.
- Round-robin fairness: with all requesters continuously requesting, each gets exactly BURST_MAX consecutive beats in the order 0,1,..,NUM_REQ-1,0,...
- Full boundary:
  - At count_o=DEPTH, no grants are issued; req_i may stay high indefinitely.
  - The first rd_ack brings the count to DEPTH-1, and a grant follows in the next cycle.
- The count never exceeds DEPTH. The FIFO is never written while full, so fifo_wr_error_i stays 0 in correct operation.

Test Plan:
- Reset, then req_i=4'b0001 with data 8'hA5 for 1 cycle -> gnt_o=0001 that cycle; next cycle fifo_wr_en_o=1, fifo_wdata_o=A5; count_o=1.
- req_i=4'b1111 held for 16 cycles, rd_ack every cycle, BURST_MAX=4 -> grants 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3; count_o stays 1 after the first grant.
- req_i[2]=1 continuously with no reads -> exactly 16 grants, then gnt_o=0 with count_o=16; one rd_ack pulse -> count_o=15, then exactly one more grant; err_o=0.
- Owner 1 drops req after 2 beats while req 3 is pending -> requester 3 is granted in the cycle req1 drops, with no idle cycle.
- Simultaneous grant and rd_ack at count 5 -> count_o stays 5. rd_ack at count 0 -> count_o stays 0 and err_o=1.
- Assert rst_i mid-burst (count 7) for 1 cycle -> gnt_o, fifo_wr_en_o and count_o go to 0 immediately; the next grant goes to requester 0 if it is requesting.
